// File: rtl/flag_cond_unit.sv
// Flag register and branch-condition resolver: captures ALU N/Z/C/V, tracks in-flight
// flag writers, and answers B.cond/CBZ/CBNZ/B requests over a valid/ready handshake.
module flag_cond_unit #(
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flag_issue,
    input  logic       flag_wr,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_v,
    input  logic       br_valid,
    output logic       br_ready,
    input  logic [1:0] br_kind,
    input  logic [3:0] br_cond,
    input  logic       br_opnd_zero,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_taken,
    output logic [3:0] flags_q,
    output logic       err_sticky
);

    localparam logic [1:0] KIND_BCOND = 2'b00;
    localparam logic [1:0] KIND_CBZ   = 2'b01;
    localparam logic [1:0] KIND_CBNZ  = 2'b10;

    logic [CNT_W-1:0] count;
    logic [3:0]       eff_flags_c;
    logic             stall_c;
    logic             accept_c;
    logic             taken_c;
    logic             cond_c;

    // A completing writer forwards its flags so a dependent B.cond need not wait a cycle.
    assign eff_flags_c = flag_wr ? {flag_n, flag_z, flag_c, flag_v} : flags_q;

    assign stall_c = (br_kind == KIND_BCOND) &&
                     ((count > CNT_W'(1)) || ((count == CNT_W'(1)) && !flag_wr));

    assign br_ready = !stall_c && (!resp_valid || resp_ready);
    assign accept_c = br_valid && br_ready;

    // ARM condition-code evaluation against the effective flags.
    always_comb begin
        logic n, z, c, v;
        n      = eff_flags_c[3];
        z      = eff_flags_c[2];
        c      = eff_flags_c[1];
        v      = eff_flags_c[0];
        cond_c = 1'b1;
        case (br_cond)
            4'b0000: cond_c = z;
            4'b0001: cond_c = !z;
            4'b0010: cond_c = c;
            4'b0011: cond_c = !c;
            4'b0100: cond_c = n;
            4'b0101: cond_c = !n;
            4'b0110: cond_c = v;
            4'b0111: cond_c = !v;
            4'b1000: cond_c = c && !z;
            4'b1001: cond_c = !c || z;
            4'b1010: cond_c = (n == v);
            4'b1011: cond_c = (n != v);
            4'b1100: cond_c = !z && (n == v);
            4'b1101: cond_c = z || (n != v);
            default: cond_c = 1'b1;
        endcase
    end

    always_comb begin
        taken_c = 1'b1;
        case (br_kind)
            KIND_BCOND: taken_c = cond_c;
            KIND_CBZ:   taken_c = br_opnd_zero;
            KIND_CBNZ:  taken_c = !br_opnd_zero;
            default:    taken_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else if (flag_wr) begin
            flags_q <= {flag_n, flag_z, flag_c, flag_v};
        end
    end

    // In-flight counter saturates at both ends and flags the protocol error instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            err_sticky <= 1'b0;
        end else begin
            case ({flag_issue, flag_wr})
                2'b10: begin
                    if (count == CNT_W'(MAX_INFLIGHT)) begin
                        err_sticky <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (count == '0) begin
                        err_sticky <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
        end else if (accept_c) begin
            resp_valid <= 1'b1;
            resp_taken <= taken_c;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: scoreboard of expected branch outcomes plus
// directed checks of stall, backpressure, counter limits and asynchronous reset.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flag_issue, flag_wr, flag_n, flag_z, flag_c, flag_v;
    logic       br_valid, br_ready, br_opnd_zero;
    logic [1:0] br_kind;
    logic [3:0] br_cond;
    logic       resp_valid, resp_ready, resp_taken;
    logic [3:0] flags_q;
    logic       err_sticky;

    int n_checks = 0;
    int n_fail   = 0;
    logic       exp_q[$];
    logic [3:0] m_flags = 4'b0000;

    flag_cond_unit #(.MAX_INFLIGHT(3), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .flag_issue(flag_issue), .flag_wr(flag_wr),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .br_valid(br_valid), .br_ready(br_ready), .br_kind(br_kind),
        .br_cond(br_cond), .br_opnd_zero(br_opnd_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_taken(resp_taken),
        .flags_q(flags_q), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_taken(input logic [1:0] k, input logic [3:0] c,
                                         input logic oz, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (k == 2'b01) return oz;
        if (k == 2'b10) return !oz;
        if (k == 2'b11) return 1'b1;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy & !z;
            4'd9:  return !cy | z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z & (n == v);
            4'd13: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Scoreboard: retire the presented response first, then enqueue a newly accepted request.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            m_flags = 4'b0000;
        end else begin
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) check("sb_unexpected_resp", 32'd1, 32'd0);
                else check("resp_taken", 32'(resp_taken), 32'(exp_q.pop_front()));
            end
            if (br_valid && br_ready)
                exp_q.push_back(model_taken(br_kind, br_cond, br_opnd_zero,
                    flag_wr ? {flag_n, flag_z, flag_c, flag_v} : m_flags));
            if (flag_wr) m_flags = {flag_n, flag_z, flag_c, flag_v};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {flag_n, flag_z, flag_c, flag_v} = f;
    endtask

    task automatic idle();
        flag_issue = 0; flag_wr = 0; br_valid = 0;
    endtask

    initial begin
        reset_n = 0; resp_ready = 1; br_kind = 0; br_cond = 0; br_opnd_zero = 0;
        idle(); set_flags(4'b0000);
        tick(); tick();
        #1;
        check("rst_flags", 32'(flags_q), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_taken", 32'(resp_taken), 32'h0);
        check("rst_err", 32'(err_sticky), 32'h0);
        check("rst_count", 32'(dut.count), 32'h0);
        reset_n = 1;
        tick();

        // Basic conditions: Z=1 -> EQ taken, NE not taken
        flag_issue = 1; tick();
        flag_issue = 0; flag_wr = 1; set_flags(4'b0100); tick();
        flag_wr = 0; br_valid = 1; br_kind = 2'b00; br_cond = 4'b0000;
        #1 check("eq_ready", 32'(br_ready), 32'h1);
        tick();
        br_cond = 4'b0001;
        #1 check("flags_0100", 32'(flags_q), 32'h4);
        check("eq_resp_valid", 32'(resp_valid), 32'h1);
        check("eq_resp_taken", 32'(resp_taken), 32'h1);
        tick();
        br_valid = 0;
        #1 check("ne_resp_taken", 32'(resp_taken), 32'h0);
        tick();

        // CBZ/CBNZ never stall, even with two writers outstanding
        flag_issue = 1; tick(); tick();
        flag_issue = 0; br_valid = 1; br_kind = 2'b01; br_opnd_zero = 1;
        #1 check("cbz_count2", 32'(dut.count), 32'h2);
        check("cbz_ready", 32'(br_ready), 32'h1);
        tick();
        br_kind = 2'b10;
        #1 check("cbnz_ready", 32'(br_ready), 32'h1);
        tick();

        // Hazard stall then bypass release on the last pending write
        br_kind = 2'b00; br_cond = 4'b1010;
        #1 check("ge_stall_cnt2", 32'(br_ready), 32'h0);
        tick();
        flag_wr = 1; set_flags(4'b0000);
        #1 check("ge_stall_wr1", 32'(br_ready), 32'h0);
        tick();
        set_flags(4'b1001);
        #1 check("ge_bypass_ready", 32'(br_ready), 32'h1);
        tick();
        idle();
        #1 check("ge_taken", 32'(resp_taken), 32'h1);
        tick();

        // Backpressure holds the response and blocks new requests
        flag_issue = 1; tick();
        flag_issue = 0; flag_wr = 1; set_flags(4'b0010); tick();
        flag_wr = 0; br_valid = 1; br_kind = 2'b00; br_cond = 4'b1000;
        #1 check("hi_ready", 32'(br_ready), 32'h1);
        tick();
        resp_ready = 0; br_kind = 2'b10; br_opnd_zero = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_resp_valid", 32'(resp_valid), 32'h1);
            check("bp_resp_taken", 32'(resp_taken), 32'h1);
            check("bp_br_ready", 32'(br_ready), 32'h0);
            tick();
        end
        resp_ready = 1;
        #1 check("bp_release_ready", 32'(br_ready), 32'h1);
        tick();
        idle();
        #1 check("cbnz_after_bp", 32'(resp_taken), 32'h0);
        tick();

        // All condition codes: bypass path, then the registered-flag path
        for (int i = 0; i < 16; i++) begin
            flag_issue = 1; tick();
            flag_issue = 0; flag_wr = 1; set_flags(4'($urandom_range(0, 15)));
            br_valid = 1; br_kind = 2'b00; br_cond = 4'(i);
            #1 check("cond_bypass_ready", 32'(br_ready), 32'h1);
            tick();
            flag_wr = 0;
            #1 check("cond_reg_ready", 32'(br_ready), 32'h1);
            tick();
            idle(); tick();
        end

        // Counter boundaries
        flag_issue = 1; flag_wr = 1; set_flags(4'b1100); tick();
        idle();
        #1 check("simul_count", 32'(dut.count), 32'h0);
        check("simul_err", 32'(err_sticky), 32'h0);
        check("simul_flags", 32'(flags_q), 32'hC);
        flag_issue = 1; tick(); tick(); tick();
        #1 check("cnt3", 32'(dut.count), 32'h3);
        check("cnt3_err", 32'(err_sticky), 32'h0);
        tick();
        flag_issue = 0;
        #1 check("ovf_count", 32'(dut.count), 32'h3);
        check("ovf_err", 32'(err_sticky), 32'h1);
        reset_n = 0;
        #1 check("rst_clears_err", 32'(err_sticky), 32'h0);
        tick();
        reset_n = 1; tick();
        flag_wr = 1; set_flags(4'b0101); tick();
        flag_wr = 0;
        #1 check("udf_count", 32'(dut.count), 32'h0);
        check("udf_err", 32'(err_sticky), 32'h1);
        check("udf_flags", 32'(flags_q), 32'h5);
        tick();

        // Asynchronous reset while a response is held and writers are outstanding
        flag_issue = 1; tick(); tick();
        flag_issue = 0; flag_wr = 0; br_valid = 1; br_kind = 2'b01; br_opnd_zero = 1;
        resp_ready = 0; tick();
        br_valid = 0;
        #1 check("pre_rst_valid", 32'(resp_valid), 32'h1);
        check("pre_rst_count", 32'(dut.count), 32'h2);
        reset_n = 0;
        #1 check("async_resp_valid", 32'(resp_valid), 32'h0);
        check("async_flags", 32'(flags_q), 32'h0);
        check("async_count", 32'(dut.count), 32'h0);
        tick();
        reset_n = 1; resp_ready = 1; tick();
        br_valid = 1; br_kind = 2'b00; br_cond = 4'b0000;
        #1 check("post_rst_ready", 32'(br_ready), 32'h1);
        tick();
        idle(); tick(); tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Consumer end of the ALU status path: registers the N/Z/C/V flags produced by the ALU (Z from the 64-bit zero checker) and resolves branch conditions against them.
- Serves the fetch/branch stage through a valid/ready request and response handshake. Covers B.cond, CBZ, CBNZ and unconditional B.
- Tracks in-flight flag-setting ALU ops and stalls B.cond until the flags it depends on are final.

Parameters:
MAX_INFLIGHT, 3, maximum number of flag-setting ops outstanding between issue and write-back.
CNT_W, 2, width of the in-flight counter; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
flag_issue  input  1  a flag-setting op has entered the ALU.
flag_wr  input  1  a flag-setting op completes; capture flag_n/z/c/v.
flag_n  input  1  negative flag from ALU.
flag_z  input  1  zero flag from ALU zero checker.
flag_c  input  1  carry flag from ALU.
flag_v  input  1  overflow flag from ALU.
br_valid  input  1  branch request present.
br_ready  output  1  request accepted this cycle when br_valid is also high.
br_kind  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B.
br_cond  input  4  ARM condition code, used only for B.cond.
br_opnd_zero  input  1  zero-checker result on the CBZ/CBNZ register operand.
resp_valid  output  1  branch resolution available.
resp_ready  input  1  consumer accepts the resolution.
resp_taken  output  1  branch taken.
flags_q  output  4  registered flags {N,Z,C,V}.
err_sticky  output  1  protocol error seen; cleared only by reset.

Behaviour:
- **Reset** (asynchronous, reset_n=0):
  - flags_q=0000, in-flight count=0, resp_valid=0, resp_taken=0, err_sticky=0.
  - Any pending response is discarded.
  - Reset mid-handshake behaves identically.
- **Flag capture:**
  - On a clk edge with flag_wr=1, flags_q takes {flag_n,flag_z,flag_c,flag_v}.
  - Otherwise flags_q holds.
- **In-flight counter:**
  - flag_issue alone: +1. flag_wr alone: −1. Both in the same cycle: unchanged.
  - flag_issue alone at count==MAX_INFLIGHT: count holds, err_sticky←1.
  - flag_wr alone at count==0: flags are still captured, count stays 0, err_sticky←1.
- **Flag source** (eff_flags): incoming flag_n/z/c/v when flag_wr=1 this cycle, else flags_q.
- **Stall:** asserted only for br_kind=00 when count>1, or when count==1 and flag_wr=0.
  - count==1 with flag_wr=1 is a bypass: no stall, evaluate with eff_flags.
  - CBZ, CBNZ and B never stall.
- **br_ready** (combinational) = !stall && (!resp_valid || resp_ready). It does not depend on br_valid.
- **Acceptance** (br_valid && br_ready): on the next edge, resp_valid←1 and resp_taken←evaluated result. Latency is one cycle.
- **Response hold:** while resp_valid && !resp_ready, resp_valid and resp_taken hold stable.
  - On resp_ready with no new acceptance: resp_valid←0.
  - Back-to-back acceptance gives full throughput.
- **Evaluation:**
  - CBZ: taken = br_opnd_zero.
  - CBNZ: taken = !br_opnd_zero.
  - B: taken = 1.
  - B.cond, using eff_flags N,Z,C,V:
    - 0000 Z; 0001 !Z; 0010 C; 0011 !C.
    - 0100 N; 0101 !N; 0110 V; 0111 !V.
    - 1000 C&!Z; 1001 !C|Z.
    - 1010 N==V; 1011 N!=V.
    - 1100 !Z&(N==V); 1101 Z|(N!=V).
    - 1110 and 1111: always taken.
- **Stall release:** a stalled B.cond held on br_valid is accepted in the cycle its last pending flag_wr arrives, through the bypass path.

Test Plan:
- **Reset then basic conditions:** flag_wr with NZCV=0100, then B.cond EQ → resp_taken=1 one cycle later, flags_q=0100. Then B.cond NE → resp_taken=0.
- **CBZ/CBNZ:** br_opnd_zero=1 with CBZ → taken=1. Same operand with CBNZ → taken=0. br_ready=1 even while count=2.
- **Hazard stall and bypass:**
  - flag_issue twice (count=2), then B.cond GE held → br_ready=0.
  - First flag_wr → still 0.
  - Second flag_wr with NZCV=1001 → br_ready=1 that cycle, resp_taken=1 (N==V).
- **Backpressure:** accept B.cond HI with C=1,Z=0, then hold resp_ready=0 for 3 cycles → resp_valid=1 and resp_taken=1 stable, br_ready=0. Release → next request accepted the same cycle.
- **Counter boundaries:**
  - Simultaneous flag_issue and flag_wr → count unchanged.
  - 4th flag_issue with MAX_INFLIGHT=3 → err_sticky=1, count=3.
  - flag_wr at count=0 → err_sticky=1, flags still captured.
- **Reset mid-operation:** drop reset_n while resp_valid=1 and count=2 → resp_valid=0, flags_q=0, count=0 immediately (asynchronous). After release, B.cond accepted without stall.
